// File: rtl/cla_multiword_seq.sv
// Multi-word adder sequencer around a single carry-lookahead slice.
// Operands of width*words bits are added one word per cycle, LSW first,
// with each word's carry-out registered and fed back as the next carry-in.

// Single-slice adder: per-bit generate/propagate with the carry chain
// resolved combinationally inside one cycle.
module carryLHTop #(
  parameter int width = 16
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cin,
  output logic [width-1:0] s,
  output logic             cout
);

  logic [width-1:0] g;
  logic [width-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // Carry recurrence c[i+1] = g[i] | p[i]&c[i], flattened by synthesis.
  always_comb begin : carry_chain
    logic cy;
    cy   = cin;
    s    = '0;
    for (int i = 0; i < width; i++) begin
      s[i] = p[i] ^ cy;
      cy   = g[i] | (p[i] & cy);
    end
    cout = cy;
  end

endmodule

// state | meaning
// IDLE  | waiting for operands, start_ready=1
// RUN   | adding word idx, carry_q holds carry into that word
// DONE  | result held on sum_out/cout_out, res_valid=1
module cla_multiword_seq #(
  parameter int width = 16,
  parameter int words = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [width*words-1:0]   a_in,
  input  logic [width*words-1:0]   b_in,
  input  logic                     cin_in,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [width*words-1:0]   sum_out,
  output logic                     cout_out
);

  localparam int iw = (words > 1) ? $clog2(words) : 1;
  localparam logic [iw-1:0] last_idx = iw'(words - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [width*words-1:0]   a_q;
  logic [width*words-1:0]   b_q;
  logic [width*words-1:0]   sum_q;
  logic                     carry_q;
  logic                     cout_q;
  logic [iw-1:0]            idx;

  logic [width-1:0]         a_word;
  logic [width-1:0]         b_word;
  logic [width-1:0]         s_word;
  logic                     c_word;

  assign a_word = a_q[idx*width +: width];
  assign b_word = b_q[idx*width +: width];

  carryLHTop #(.width(width)) u_slice (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_q),
    .s    (s_word),
    .cout (c_word)
  );

  // Sequencer: capture operands, walk the words, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= cin_in;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*width +: width] <= s_word;
          carry_q                   <= c_word;
          if (idx == last_idx) begin
            cout_q <= c_word;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign sum_out     = sum_q;
  assign cout_out    = cout_q;

endmodule
